// File: rtl/com_slink_mm_txbuf.sv
// Packet buffer feeding the serial-link transmitter: collects producer words, exposes
// only fully committed packets, and answers per-word read requests with framed data.
module com_slink_mm_txbuf #(
  parameter int DEPTH_LOG2  = 9,
  parameter int MAX_PKT_LEN = 256
) (
  input  logic        clk_12_5m,
  input  logic        rst_12_5m,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        wr_last,
  output logic        wr_ready,
  input  logic        slink_mm_rdreq,
  output logic [17:0] mm_slink_data,
  output logic        mm_slink_dval,
  output logic [7:0]  pkt_cnt,
  output logic        wr_drop
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DISCARD} state_t;

  state_t      state_q, state_d;
  ptr_t        wptr, cptr, rptr;
  ptr_t        wptr_d, cptr_d;
  ptr_t        used;
  logic [8:0]  len, len_d;
  logic        full;
  logic        mem_we;
  logic        commit;
  logic        drop_d;
  logic        rd_acc_p0;
  logic        eop_rd;
  logic [17:0] mem [DEPTH];

  // One slot stays empty so that wptr == rptr always means "empty".
  assign used      = wptr - rptr;
  assign full      = (used == ptr_t'(DEPTH - 1));
  assign rd_acc_p0 = slink_mm_rdreq && (rptr != cptr);
  assign eop_rd    = mm_slink_dval && mm_slink_data[16];

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr;
    cptr_d   = cptr;
    len_d    = len;
    wr_ready = 1'b1;
    mem_we   = 1'b0;
    commit   = 1'b0;
    drop_d   = 1'b0;
    case (state_q)
      S_IDLE, S_FILL: begin
        wr_ready = !full;
        if (wr_en && full) begin
          // Overflow: rewind to the last committed packet boundary.
          wptr_d  = cptr;
          len_d   = 9'd0;
          if (wr_last) begin
            drop_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DISCARD;
          end
        end else if (wr_en) begin
          if ((len == 9'(MAX_PKT_LEN)) && !wr_last) begin
            wptr_d  = cptr;
            len_d   = 9'd0;
            state_d = S_DISCARD;
          end else begin
            mem_we = 1'b1;
            wptr_d = wptr + ptr_t'(1);
            if (wr_last) begin
              cptr_d  = wptr + ptr_t'(1);
              len_d   = 9'd0;
              commit  = 1'b1;
              state_d = S_IDLE;
            end else begin
              len_d   = len + 9'd1;
              state_d = S_FILL;
            end
          end
        end
      end
      S_DISCARD: begin
        if (wr_en && wr_last) begin
          drop_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_12_5m) begin
    if (mem_we) begin
      mem[wptr] <= {(len == 9'd0), wr_last, wr_data};
    end
  end

  // Stage p0 -> p1: accepted request registers the framed word and its strobe.
  always_ff @(posedge clk_12_5m) begin
    if (rst_12_5m) begin
      state_q       <= S_IDLE;
      wptr          <= '0;
      cptr          <= '0;
      rptr          <= '0;
      len           <= 9'd0;
      pkt_cnt       <= 8'd0;
      wr_drop       <= 1'b0;
      mm_slink_dval <= 1'b0;
      mm_slink_data <= 18'd0;
    end else begin
      state_q       <= state_d;
      wptr          <= wptr_d;
      cptr          <= cptr_d;
      len           <= len_d;
      wr_drop       <= drop_d;
      mm_slink_dval <= rd_acc_p0;
      if (rd_acc_p0) begin
        mm_slink_data <= mem[rptr];
        rptr          <= rptr + ptr_t'(1);
      end
      case ({commit, eop_rd})
        2'b10:   if (pkt_cnt != 8'hFF) pkt_cnt <= pkt_cnt + 8'd1;
        2'b01:   if (pkt_cnt != 8'h00) pkt_cnt <= pkt_cnt - 8'd1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_com_slink_mm_txbuf.sv
// Bench for com_slink_mm_txbuf: a per-cycle vector table plus scoreboarded sequences
// for overflow, over-length, wrap-around streaming and mid-packet reset.
module tb_com_slink_mm_txbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        wr_en, wr_last, rdreq;
  logic [15:0] wr_data;

  logic        a_ready, a_dval, a_drop, b_ready, b_dval, b_drop;
  logic [17:0] a_data, b_data;
  logic [7:0]  a_cnt, b_cnt;

  logic        o_ready, o_dval, o_drop;
  logic [17:0] o_data;
  logic [7:0]  o_cnt;

  always #5 clk = ~clk;

  com_slink_mm_txbuf #(.DEPTH_LOG2(4), .MAX_PKT_LEN(256)) u_a (
    .clk_12_5m(clk), .rst_12_5m(rst),
    .wr_en(wr_en && !sel), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(a_ready),
    .slink_mm_rdreq(rdreq && !sel), .mm_slink_data(a_data), .mm_slink_dval(a_dval),
    .pkt_cnt(a_cnt), .wr_drop(a_drop)
  );

  com_slink_mm_txbuf #(.DEPTH_LOG2(4), .MAX_PKT_LEN(8)) u_b (
    .clk_12_5m(clk), .rst_12_5m(rst),
    .wr_en(wr_en && sel), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(b_ready),
    .slink_mm_rdreq(rdreq && sel), .mm_slink_data(b_data), .mm_slink_dval(b_dval),
    .pkt_cnt(b_cnt), .wr_drop(b_drop)
  );

  assign o_ready = sel ? b_ready : a_ready;
  assign o_dval  = sel ? b_dval  : a_dval;
  assign o_drop  = sel ? b_drop  : a_drop;
  assign o_data  = sel ? b_data  : a_data;
  assign o_cnt   = sel ? b_cnt   : a_cnt;

  typedef struct {
    logic        we;
    logic [15:0] wd;
    logic        wl;
    logic        rd;
    logic        e_rdy;
    logic [7:0]  e_cnt;
    logic        e_dval;
    logic [17:0] e_data;
    logic        e_drop;
  } vec_t;

  vec_t        vec [17];
  logic [17:0] exp_q [$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          n_dval   = 0;
  int          drop_cnt = 0;
  int          max_cnt  = 0;
  bit          sb_en    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic sample();
    if (o_dval) begin
      n_dval++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected_dval: actual data=0x%0h required=no dval", o_data);
      end else begin
        chk("sb_data", 32'(o_data), 32'(exp_q.pop_front()));
      end
    end
    if (o_drop) drop_cnt++;
    if (int'(o_cnt) > max_cnt) max_cnt = int'(o_cnt);
  endtask

  // Inputs are driven just after a rising edge, outputs sampled on the falling edge.
  task automatic step();
    @(negedge clk);
    if (sb_en) sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; wr_last = 1'b0; wr_data = 16'h0; rdreq = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int k = 0;
    while (exp_q.size() != 0 && k < max_cyc) begin
      step();
      k++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int d0, v0, g;
    logic [15:0] wd;

    //            we    wd        wl    rd    rdy   cnt    dval  data        drop
    vec[0]  = '{1'b1, 16'h1111, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 18'h00000, 1'b0};
    vec[1]  = '{1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 18'h00000, 1'b0};
    vec[2]  = '{1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 18'h00000, 1'b0};
    vec[3]  = '{1'b1, 16'h4444, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 18'h00000, 1'b0};
    vec[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 18'h00000, 1'b0};
    vec[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 18'h21111, 1'b0};
    vec[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 18'h02222, 1'b0};
    vec[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 18'h03333, 1'b0};
    vec[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 18'h14444, 1'b0};
    vec[9]  = '{1'b1, 16'hA001, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 18'h14444, 1'b0};
    vec[10] = '{1'b1, 16'hA002, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 18'h14444, 1'b0};
    vec[11] = '{1'b1, 16'hA003, 1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 18'h14444, 1'b0};
    vec[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 18'h14444, 1'b0};
    vec[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 18'h2A001, 1'b0};
    vec[14] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 18'h0A002, 1'b0};
    vec[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 18'h1A003, 1'b0};
    vec[16] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 18'h1A003, 1'b0};

    sel = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset values on both instances
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_a_cnt",   32'(a_cnt),   32'd0);
    chk("rst_a_dval",  32'(a_dval),  32'd0);
    chk("rst_a_data",  32'(a_data),  32'd0);
    chk("rst_a_drop",  32'(a_drop),  32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd1);
    chk("rst_b_cnt",   32'(b_cnt),   32'd0);
    chk("rst_b_dval",  32'(b_dval),  32'd0);

    // Commit-then-read and no-early-read, cycle by cycle
    for (int i = 0; i < 17; i++) begin
      wr_en = vec[i].we; wr_data = vec[i].wd; wr_last = vec[i].wl; rdreq = vec[i].rd;
      chk($sformatf("vec%0d_ready", i), 32'(o_ready), 32'(vec[i].e_rdy));
      chk($sformatf("vec%0d_cnt",   i), 32'(o_cnt),   32'(vec[i].e_cnt));
      chk($sformatf("vec%0d_dval",  i), 32'(o_dval),  32'(vec[i].e_dval));
      chk($sformatf("vec%0d_data",  i), 32'(o_data),  32'(vec[i].e_data));
      chk($sformatf("vec%0d_drop",  i), 32'(o_drop),  32'(vec[i].e_drop));
      step();
    end

    sb_en = 1'b1;

    // Overflow: 20-word packet into a 15-word buffer
    do_reset();
    sel = 1'b0; d0 = drop_cnt; v0 = n_dval;
    for (int i = 0; i < 15; i++) begin
      wr_en = 1'b1; wr_data = 16'h0F00 + 16'(i); wr_last = 1'b0;
      chk("ovf_ready_pre", 32'(o_ready), 32'd1);
      step();
    end
    chk("ovf_ready_full", 32'(o_ready), 32'd0);
    wr_data = 16'h0F0F;
    step();
    chk("ovf_ready_discard", 32'(o_ready), 32'd1);
    for (int i = 16; i < 20; i++) begin
      wr_data = 16'h0F00 + 16'(i); wr_last = (i == 19);
      step();
    end
    wr_en = 1'b0; wr_last = 1'b0;
    step();
    step();
    chk("ovf_drop_once", 32'(drop_cnt - d0), 32'd1);
    chk("ovf_pkt_cnt",   32'(o_cnt),         32'd0);
    chk("ovf_wptr",      32'(u_a.wptr),      32'd0);
    chk("ovf_cptr",      32'(u_a.cptr),      32'd0);
    chk("ovf_rptr",      32'(u_a.rptr),      32'd0);
    rdreq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ovf_no_dval", 32'(o_dval), 32'd0);
    end
    rdreq = 1'b0;
    chk("ovf_dval_total", 32'(n_dval - v0), 32'd0);

    // Over-length: 10-word packet with MAX_PKT_LEN=8, then a valid 2-word packet
    do_reset();
    sel = 1'b1; d0 = drop_cnt; v0 = n_dval;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 16'hE000 + 16'(i); wr_last = (i == 9);
      step();
    end
    wr_en = 1'b1; wr_data = 16'hB001; wr_last = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 16'hB001});
    step();
    wr_data = 16'hB002; wr_last = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 16'hB002});
    step();
    wr_en = 1'b0; wr_last = 1'b0; rdreq = 1'b1;
    wait_drain("olen_drain", 10);
    rdreq = 1'b0;
    step();
    step();
    chk("olen_drop_once", 32'(drop_cnt - d0), 32'd1);
    chk("olen_dval_cnt",  32'(n_dval - v0),   32'd2);
    chk("olen_pkt_cnt",   32'(o_cnt),         32'd0);

    // Wrap and simultaneity: 50 three-word packets with continuous reads
    do_reset();
    sel = 1'b0; v0 = n_dval; max_cnt = 0; rdreq = 1'b1;
    for (int p = 0; p < 50; p++) begin
      for (int w = 0; w < 3; w++) begin
        wd = 16'h5000 + 16'(p * 4 + w);
        wr_en = 1'b1; wr_data = wd; wr_last = (w == 2);
        g = 0;
        while (!o_ready && g < 20) begin
          step();
          g++;
        end
        chk("wrap_ready", 32'(o_ready), 32'd1);
        exp_q.push_back({(w == 0), (w == 2), wd});
        step();
      end
    end
    wr_en = 1'b0; wr_last = 1'b0;
    wait_drain("wrap_drain", 50);
    step();
    rdreq = 1'b0;
    chk("wrap_dval_cnt", 32'(n_dval - v0),   32'd150);
    chk("wrap_max_le5",  32'(max_cnt <= 5),  32'd1);
    chk("wrap_pkt_cnt",  32'(o_cnt),         32'd0);

    // Reset during FILL and during a dval
    do_reset();
    sel = 1'b0; d0 = drop_cnt;
    wr_en = 1'b1; wr_data = 16'hC001; wr_last = 1'b1;
    exp_q.push_back(18'h3C001);
    step();
    wr_data = 16'hC002; wr_last = 1'b0; rdreq = 1'b1;
    step();
    chk("mid_dval_before_rst", 32'(o_dval), 32'd1);
    wr_data = 16'hC003; rdreq = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; wr_en = 1'b0;
    chk("mid_rst_dval",  32'(o_dval),   32'd0);
    chk("mid_rst_data",  32'(o_data),   32'd0);
    chk("mid_rst_cnt",   32'(o_cnt),    32'd0);
    chk("mid_rst_drop",  32'(o_drop),   32'd0);
    chk("mid_rst_ready", 32'(o_ready),  32'd1);
    chk("mid_rst_wptr",  32'(u_a.wptr), 32'd0);
    wr_en = 1'b1; wr_data = 16'hD00D; wr_last = 1'b1;
    exp_q.push_back(18'h3D00D);
    step();
    wr_en = 1'b0; wr_last = 1'b0; rdreq = 1'b1;
    wait_drain("mid_drain", 5);
    rdreq = 1'b0;
    step();
    chk("mid_pkt_cnt",  32'(o_cnt),            32'd0);
    chk("mid_no_drop",  32'(drop_cnt - d0),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
